// File: rtl/serial_transmitter_if.sv
// Byte-request / serial-line bundle for the serial transmitter.
// The requester drives tx_data/tx_en; the transmitter drives the line and status flags.
interface serial_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       dout;
    logic       tx_status;
    logic       tx_done;

    modport master (
        output tx_data,
        output tx_en,
        input  dout,
        input  tx_status,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_en,
        output dout,
        output tx_status,
        output tx_done
    );
endinterface

// File: rtl/serial_transmitter.sv
// Serialises one byte per request: start bit, 8 data bits LSB first, optional parity, stop bit.
// Every output is registered from the next-state values so the line changes exactly on bit boundaries.
module serial_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_transmitter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int DIV_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    // Mode 3 falls back to no parity, same as mode 0.
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 2);

    state_t           state_reg,  state_next;
    logic [DIV_W-1:0] div_reg,    div_next;
    logic [3:0]       bit_reg,    bit_next;
    logic [7:0]       shift_reg,  shift_next;
    logic             parity_reg, parity_next;
    logic             dout_reg,   dout_next;
    logic             status_reg, status_next;
    logic             done_reg,   done_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            div_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            dout_reg   <= 1'b1;
            status_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            dout_reg   <= dout_next;
            status_reg <= status_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;

        if (state_reg == S_IDLE) begin
            if (bus.tx_en) begin
                state_next  = S_START;
                div_next    = '0;
                bit_next    = '0;
                shift_next  = bus.tx_data;
                parity_next = (^bus.tx_data) ^ PAR_ODD;
            end
        end else if (div_reg == DIV_LAST) begin
            div_next = '0;
            case (state_reg)
                S_START: begin
                    state_next = S_DATA;
                    bit_next   = '0;
                end
                S_DATA: begin
                    if (bit_reg == 4'd7) begin
                        state_next = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_next   = bit_reg + 4'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                    end
                end
                S_PARITY: state_next = S_STOP;
                S_STOP:   state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end else begin
            div_next = div_reg + DIV_ONE;
        end

        // Outputs follow the state being entered so they are valid for the whole cycle after the edge.
        dout_next = 1'b1;
        case (state_next)
            S_START:  dout_next = 1'b0;
            S_DATA:   dout_next = shift_next[0];
            S_PARITY: dout_next = parity_next;
            default:  dout_next = 1'b1;
        endcase
        status_next = (state_next != S_IDLE);
        done_next   = (state_next == S_STOP) && (div_next == DIV_LAST);
    end

    assign bus.dout      = dout_reg;
    assign bus.tx_status = status_reg;
    assign bus.tx_done   = done_reg;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench: three transmitters (no/even/odd parity, 4 clocks per bit) share one request stream;
// captured line/status/done traces are compared with traces built from the frame format.
module tb_serial_transmitter;

    localparam int NCAP = 92;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b1;
    logic [7:0] tx_data = 8'h00;

    int n_cmp = 0;
    int n_mis = 0;

    logic [127:0] tr_d [3];
    logic [127:0] tr_s [3];
    logic [127:0] tr_k [3];

    serial_transmitter_if bus0 ();
    serial_transmitter_if bus1 ();
    serial_transmitter_if bus2 ();

    assign bus0.tx_en = tx_en;  assign bus0.tx_data = tx_data;
    assign bus1.tx_en = tx_en;  assign bus1.tx_data = tx_data;
    assign bus2.tx_en = tx_en;  assign bus2.tx_data = tx_data;

    serial_transmitter #(.CLKS_PER_BIT(4), .PARITY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    serial_transmitter #(.CLKS_PER_BIT(4), .PARITY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    serial_transmitter #(.CLKS_PER_BIT(4), .PARITY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] d, input int mode, input int b);
        if (b == 0)
            return 1'b0;
        else if (b <= 8)
            return d[b-1];
        else if (b == 9 && mode == 1)
            return ^d;
        else if (b == 9 && mode == 2)
            return ~(^d);
        else
            return 1'b1;
    endfunction

    // Expected traces for one frame, or two frames separated by a single idle cycle.
    task automatic model(input logic [7:0] d0, input logic [7:0] d1, input int mode, input bit two,
                         output logic [127:0] ed, output logic [127:0] es, output logic [127:0] ek);
        int len;
        len = (mode == 1 || mode == 2) ? 44 : 40;
        ed = '0; es = '0; ek = '0;
        for (int i = 0; i < NCAP; i++) begin
            ed[i] = 1'b1;
            if (i < len) begin
                ed[i] = line_bit(d0, mode, i / 4);
                es[i] = 1'b1;
                ek[i] = (i == len - 1);
            end else if (two && i > len && i <= 2 * len) begin
                ed[i] = line_bit(d1, mode, (i - len - 1) / 4);
                es[i] = 1'b1;
                ek[i] = (i == 2 * len);
            end
        end
    endtask

    // Request is raised here; sample i=0 is the first cycle after the accepting edge.
    task automatic capture(input logic [7:0] d, input int drop_at,
                           input int ev_at, input logic [7:0] ev_data, input int ev_len);
        tx_data = d;
        tx_en   = 1'b1;
        for (int m = 0; m < 3; m++) begin
            tr_d[m] = '0; tr_s[m] = '0; tr_k[m] = '0;
        end
        for (int i = 0; i < NCAP; i++) begin
            @(negedge clk);
            tr_d[0][i] = bus0.dout; tr_s[0][i] = bus0.tx_status; tr_k[0][i] = bus0.tx_done;
            tr_d[1][i] = bus1.dout; tr_s[1][i] = bus1.tx_status; tr_k[1][i] = bus1.tx_done;
            tr_d[2][i] = bus2.dout; tr_s[2][i] = bus2.tx_status; tr_k[2][i] = bus2.tx_done;
            if (i == drop_at) tx_en = 1'b0;
            if (i == ev_at) begin
                tx_en   = 1'b1;
                tx_data = ev_data;
            end
            if (ev_len > 0 && i == ev_at + ev_len) tx_en = 1'b0;
        end
        tx_en = 1'b0;
    endtask

    task automatic compare_all(input string tag, input logic [7:0] d0, input logic [7:0] d1, input bit two);
        logic [127:0] ed, es, ek;
        for (int m = 0; m < 3; m++) begin
            model(d0, d1, m, two, ed, es, ek);
            check_val($sformatf("%s_dout_p%0d", tag, m), tr_d[m], ed);
            check_val($sformatf("%s_status_p%0d", tag, m), tr_s[m], es);
            check_val($sformatf("%s_done_p%0d", tag, m), tr_k[m], ek);
        end
    endtask

    initial begin
        // Reset held with a pending request: line idle, no frame.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val($sformatf("reset_c%0d_p0", c), {bus0.dout, bus0.tx_status, bus0.tx_done}, 3'b100);
            check_val($sformatf("reset_c%0d_p1", c), {bus1.dout, bus1.tx_status, bus1.tx_done}, 3'b100);
            check_val($sformatf("reset_c%0d_p2", c), {bus2.dout, bus2.tx_status, bus2.tx_done}, 3'b100);
        end
        rst   = 1'b0;
        tx_en = 1'b0;
        @(negedge clk);
        check_val("idle_after_reset", {bus0.dout, bus0.tx_status, bus1.dout, bus2.dout}, 4'b1011);

        // Single frame 0xA5 with one-cycle request.
        capture(8'hA5, 0, -1, 8'h00, 0);
        compare_all("single_a5", 8'hA5, 8'h00, 1'b0);
        check_val("single_status_len_p0", 128'($countones(tr_s[0])), 128'd40);
        check_val("single_status_len_p1", 128'($countones(tr_s[1])), 128'd44);
        check_val("single_parity_bit_p1", 128'(tr_d[1][37]), 128'd0);
        check_val("single_parity_bit_p2", 128'(tr_d[2][37]), 128'd1);

        // Busy ignore: a request for 0xFF mid-frame is neither sent nor queued.
        capture(8'h3C, 0, 10, 8'hFF, 1);
        compare_all("busy_3c", 8'h3C, 8'h00, 1'b0);

        // Back-to-back with tx_en held high; data switches to 0x80 during frame one.
        capture(8'h01, 50, 20, 8'h80, 0);
        compare_all("b2b_01_80", 8'h01, 8'h80, 1'b1);
        check_val("b2b_done_count_p0", 128'($countones(tr_k[0])), 128'd2);

        // Reset during data bit 3: line returns high immediately, no done pulse.
        tx_data = 8'hC3;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (17) @(negedge clk);
        check_val("pre_reset_busy", {bus0.tx_status, bus1.tx_status, bus2.tx_status}, 3'b111);
        rst = 1'b1;
        #1;
        check_val("async_reset_line", {bus0.dout, bus1.dout, bus2.dout}, 3'b111);
        check_val("async_reset_status", {bus0.tx_status, bus1.tx_status, bus2.tx_status,
                                         bus0.tx_done, bus1.tx_done, bus2.tx_done}, 6'b000000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus0.tx_done || bus1.tx_done || bus2.tx_done || !bus0.dout) begin
                check_val($sformatf("post_reset_quiet_c%0d", c),
                          {bus0.tx_done, bus1.tx_done, bus2.tx_done, bus0.dout}, 4'b0001);
            end
        end
        check_val("post_reset_idle", {bus0.dout, bus0.tx_status, bus0.tx_done}, 3'b100);

        capture(8'h55, 0, -1, 8'h00, 0);
        compare_all("after_reset_55", 8'h55, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- Transmit side of the team's serial link: serialises one byte per request onto `dout`.
- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- Bit timing comes from an internal divider on the single system clock.
- Output line is compatible with the existing sampler-based receiver: idle-high line, LSB-first 8-bit data.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd; value 3 is treated as 0.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous reset, active high.
- tx_data  input  8  byte to send; sampled only when a request is accepted.
- tx_en  input  1  transmit request; level-sensitive, accepted only in IDLE.
- dout  output  1  serial line; idle level 1.
- tx_status  output  1  1 while a frame is in progress (from request accept through the last stop-bit cycle).
- tx_done  output  1  one-cycle pulse on the last clk cycle of the stop bit.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is asynchronous and active-high.
- Reset values: `dout`=1, `tx_status`=0, `tx_done`=0; shift register 0, bit counter 0, divider 0, state IDLE.
- Reset takes effect immediately, including mid-frame.
  - The line returns to 1 at once; the partial frame is abandoned.
  - No `tx_done` pulse is generated for the abandoned frame.
- All outputs are registered.
- States and transitions:
  - IDLE -> START when `tx_en`=1 at a clk edge. On that edge: latch `tx_data`, `tx_status`<=1, `dout`<=0.
  - START lasts CLKS_PER_BIT cycles, then -> DATA.
  - DATA: 8 bits, bit 0 first, each held CLKS_PER_BIT cycles. After bit 7 -> PARITY if PARITY is 1 or 2, else -> STOP.
  - PARITY: one bit time.
    - Even mode: XOR of the latched byte.
    - Odd mode: inverted XOR of the latched byte.
  - STOP: `dout`=1 for CLKS_PER_BIT cycles. `tx_done`=1 during the final cycle. Next edge -> IDLE with `tx_status`<=0 and `tx_done`<=0.
- Latency and frame length:
  - Request accepted at edge N: start bit drives `dout` from edge N.
  - Frame occupies exactly CLKS_PER_BIT×10 cycles (×11 with parity).
- Divider: counts 0..CLKS_PER_BIT-1 and wraps. Width is the minimum needed for CLKS_PER_BIT-1. Bit index is a 4-bit counter.
- Back-to-back frames: if `tx_en`=1 on the edge that returns the block to IDLE, nothing is accepted on that edge. The request is accepted on the next edge, giving exactly one idle cycle (`dout`=1) between frames.
- `tx_en` while `tx_status`=1 is ignored and not queued. `tx_data` changes during a frame have no effect.
- `tx_en` held continuously high produces repeated frames, each separated by one idle cycle.
- Simultaneous `rst` and `tx_en`: reset wins; no frame starts until `rst` deasserts and a later edge sees `tx_en`=1.

Test Plan:
- Reset: assert `rst` for 3 cycles with `tx_en`=1 -> `dout`=1, `tx_status`=0, `tx_done`=0 throughout; no start bit.
- Single frame, CLKS_PER_BIT=4, PARITY=0, `tx_data`=0xA5, one-cycle `tx_en`:
  - `dout` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `tx_status` high 40 cycles.
  - `tx_done` high only on cycle 40.
- Parity, CLKS_PER_BIT=4, `tx_data`=0xA5:
  - PARITY=1 -> 9th bit after start = 0.
  - PARITY=2 -> 9th bit = 1.
  - Frame length 44 cycles in both modes.
- Busy ignore: start 0x3C, then pulse `tx_en` with `tx_data`=0xFF mid-frame -> transmitted bits match 0x3C (0,0,1,1,1,1,0,0); no second frame follows.
- Back-to-back: `tx_en` held high, data 0x01 then 0x80 -> two complete frames with exactly one idle cycle (`dout`=1) between them; `tx_done` pulses twice.
- Reset mid-frame: assert `rst` during data bit 3 -> `dout`=1 in the same cycle, no `tx_done`; after release, a new `tx_en` with 0x55 transmits a correct full frame.
